// File: rtl/ride_uart_tx.sv
// Serial report-line transmitter: sends "D=dddd S=ss\r\n" over a UART line at BAUD.
// Define RIDE_UART_PARITY_EN to add an even-parity bit after each byte's data bits.
`timescale 1ns/1ps

module ride_uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] distThousands,
  input  logic [6:0] distHundreds,
  input  logic [6:0] distTens,
  input  logic [6:0] distOnes,
  input  logic [6:0] speedTens,
  input  logic [6:0] speedOnes,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int              DIV       = CLK_FREQ_HZ / BAUD;
  localparam int              CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]      LAST_BYTE = 4'd12;
  localparam logic [6:0]      ASCII_0   = 7'h30;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RIDE_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [3:0]       byte_idx, byte_idx_nx;
  logic             tx_nx, busy_nx, done_nx;
  logic             bit_end;
  logic             accept;
  logic [6:0]       code;
  logic [7:0]       cur_byte;
  logic [6:0]       snap_d3, snap_d2, snap_d1, snap_d0, snap_s1, snap_s0;

  function automatic logic [6:0] sanitize(input logic [6:0] c);
    return (c >= 7'h30 && c <= 7'h39) ? c : 7'h3F;
  endfunction

  assign bit_end = (baud_cnt == CNT_LAST);
  assign accept  = (state == IDLE) && start;

  // Character at the current byte position of the report line.
  always_comb begin
    code = 7'h0A;
    case (byte_idx)
      4'd0:    code = 7'h44;
      4'd1:    code = 7'h3D;
      4'd2:    code = snap_d3;
      4'd3:    code = snap_d2;
      4'd4:    code = snap_d1;
      4'd5:    code = snap_d0;
      4'd6:    code = 7'h20;
      4'd7:    code = 7'h53;
      4'd8:    code = 7'h3D;
      4'd9:    code = snap_s1;
      4'd10:   code = snap_s0;
      4'd11:   code = 7'h0D;
      default: code = 7'h0A;
    endcase
    cur_byte = {1'b0, code};
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_idx_nx  = bit_idx;
    byte_idx_nx = byte_idx;
    tx_nx       = tx;
    busy_nx     = busy;
    done_nx     = 1'b0;

    if (state == IDLE) begin
      tx_nx       = 1'b1;
      busy_nx     = 1'b0;
      baud_cnt_nx = '0;
      bit_idx_nx  = '0;
      byte_idx_nx = '0;
      if (accept) begin
        state_nx = START;
        tx_nx    = 1'b0;
        busy_nx  = 1'b1;
      end
    end else if (!bit_end) begin
      baud_cnt_nx = baud_cnt + CNT_W'(1);
    end else begin
      // Bit boundary: load tx with the next bit so the line changes on this edge.
      baud_cnt_nx = '0;
      case (state)
        START: begin
          state_nx   = DATA;
          bit_idx_nx = '0;
          tx_nx      = cur_byte[0];
        end
        DATA: begin
          if (bit_idx != 3'd7) begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = cur_byte[bit_idx + 3'd1];
          end else begin
`ifdef RIDE_UART_PARITY_EN
            state_nx = PARITY;
            tx_nx    = ^cur_byte;
`else
            state_nx = STOP;
            tx_nx    = 1'b1;
`endif
          end
        end
`ifdef RIDE_UART_PARITY_EN
        PARITY: begin
          state_nx = STOP;
          tx_nx    = 1'b1;
        end
`endif
        STOP: begin
          if (byte_idx != LAST_BYTE) begin
            byte_idx_nx = byte_idx + 4'd1;
            state_nx    = START;
            tx_nx       = 1'b0;
          end else begin
            byte_idx_nx = '0;
            state_nx    = IDLE;
            tx_nx       = 1'b1;
            busy_nx     = 1'b0;
            done_nx     = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      byte_idx <= byte_idx_nx;
      tx       <= tx_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // NOTE: the snapshot is a handful of flops, not a memory, so it takes a defined reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_d3 <= ASCII_0;
      snap_d2 <= ASCII_0;
      snap_d1 <= ASCII_0;
      snap_d0 <= ASCII_0;
      snap_s1 <= ASCII_0;
      snap_s0 <= ASCII_0;
    end else if (accept) begin
      snap_d3 <= sanitize(distThousands);
      snap_d2 <= sanitize(distHundreds);
      snap_d1 <= sanitize(distTens);
      snap_d0 <= sanitize(distOnes);
      snap_s1 <= sanitize(speedTens);
      snap_s0 <= sanitize(speedOnes);
    end
  end

endmodule

// File: tb/tb_ride_uart_tx.sv
// Self-checking bench for ride_uart_tx: a UART receiver decodes tx and compares each byte
// against a scoreboard of expected line bytes pushed when start is driven.
`timescale 1ns/1ps

module tb_ride_uart_tx;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int BAUD        = 100_000;
  localparam int DIV         = 10;
  localparam int LINE_LEN    = 13;
`ifdef RIDE_UART_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int LINE_CYCLES = BITS * LINE_LEN * DIV;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] distThousands, distHundreds, distTens, distOnes;
  logic [6:0] speedTens, speedOnes;
  logic       tx, busy, done;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_bytes[LINE_LEN];

  ride_uart_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .distThousands(distThousands),
    .distHundreds (distHundreds),
    .distTens     (distTens),
    .distOnes     (distOnes),
    .speedTens    (speedTens),
    .speedOnes    (speedOnes),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_bad++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [7:0] digit_model(input logic [6:0] c);
    return (c >= 7'h30 && c <= 7'h39) ? {1'b0, c} : 8'h3F;
  endfunction

  task automatic set_digits(input logic [6:0] d3, d2, d1, d0, s1, s0);
    distThousands = d3; distHundreds = d2; distTens = d1; distOnes = d0;
    speedTens = s1; speedOnes = s0;
  endtask

  task automatic push_line();
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h3D);
    exp_q.push_back(digit_model(distThousands));
    exp_q.push_back(digit_model(distHundreds));
    exp_q.push_back(digit_model(distTens));
    exp_q.push_back(digit_model(distOnes));
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h3D);
    exp_q.push_back(digit_model(speedTens));
    exp_q.push_back(digit_model(speedOnes));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Returns at the negedge inside the first cycle of the start bit of a correctly accepted line.
  task automatic send_start();
    @(negedge clk);
    push_line();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Decodes one line from tx, sampling mid-bit; first_bound limits the wait for the first start bit.
  task automatic rx_line(input int first_bound);
    logic [7:0] d;
    logic [7:0] e;
    logic       p;
    int         n;
    int         bound;
    for (int b = 0; b < LINE_LEN; b++) begin
      n = 0;
      bound = (b == 0) ? first_bound : DIV;
      while (tx !== 1'b0 && n < bound) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (tx !== 1'b0) begin
        errors++;
        $display("FAIL rx_start_bit: byte %0d tx=%b after %0d cycles, required 0", b, tx, n);
        return;
      end
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        d[i] = tx;
      end
      p = 1'b0;
`ifdef RIDE_UART_PARITY_EN
      repeat (DIV) @(negedge clk);
      p = tx;
`endif
      repeat (DIV) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL rx_stop_bit: byte %0d tx=%b, required 1", b, tx);
      end
      rx_bytes[b] = d;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: byte %0d got 0x%02h, required no byte", b, d);
      end else begin
        e = exp_q.pop_front();
        if (d !== e) begin
          errors++;
          $display("FAIL rx_byte: byte %0d got 0x%02h, required 0x%02h", b, d, e);
        end
`ifdef RIDE_UART_PARITY_EN
        checks++;
        if (p !== ^e) begin
          errors++;
          $display("FAIL rx_parity: byte %0d got %b, required %b", b, p, ^e);
        end
`endif
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    start = 1'b0;
    set_digits(7'h30, 7'h30, 7'h30, 7'h30, 7'h30, 7'h30);
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
    end
    reset = 1'b1;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_500: %0d cycles left idle, required 0", bad);
    end
  endtask

  task automatic test_frame();
    int b0, d0;
    set_digits(7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35);
    b0 = busy_cnt;
    d0 = done_cnt;
    send_start();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_latency: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    end
    rx_line(2);
    repeat (DIV) @(negedge clk);
    checks++;
    if (busy_cnt - b0 !== LINE_CYCLES) begin
      errors++;
      $display("FAIL frame_busy_cycles: got %0d, required %0d", busy_cnt - b0, LINE_CYCLES);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL frame_done_pulses: got %0d, required 1", done_cnt - d0);
    end
    checks++;
    if (done_bad !== 0) begin
      errors++;
      $display("FAIL done_with_busy: %0d done cycles had busy high, required 0", done_bad);
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end_idle: tx=%b busy=%b, required 1 0", tx, busy);
    end
  endtask

  task automatic test_stability();
    int b0, d0;
    set_digits(7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35);
    b0 = busy_cnt;
    d0 = done_cnt;
    send_start();
    fork
      rx_line(2);
      begin
        repeat (49) @(negedge clk);
        set_digits(7'h39, 7'h39, 7'h39, 7'h39, 7'h39, 7'h39);
        repeat (150) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (DIV + 300) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || busy_cnt - b0 !== LINE_CYCLES) begin
      errors++;
      $display("FAIL ignore_start: done=%0d busy_cycles=%0d, required 1 and %0d",
               done_cnt - d0, busy_cnt - b0, LINE_CYCLES);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL stability_queue: %0d bytes unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_invalid_digit();
    set_digits(7'h30, 7'h30, 7'h41, 7'h30, 7'h30, 7'h30);
    send_start();
    rx_line(2);
    repeat (DIV) @(negedge clk);
    checks++;
    if (rx_bytes[4] !== 8'h3F || rx_bytes[5] !== 8'h30) begin
      errors++;
      $display("FAIL invalid_digit: got 0x%02h 0x%02h, required 0x3f 0x30", rx_bytes[4], rx_bytes[5]);
    end
  endtask

  task automatic test_back_to_back();
    int d0, n;
    d0 = done_cnt;
    set_digits(7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36);
    send_start();
    rx_line(2);
    set_digits(7'h39, 7'h38, 7'h37, 7'h36, 7'h35, 7'h34);
    n = 0;
    while (done !== 1'b1 && n < 2 * DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b after %0d cycles, required 1", done, n);
    end
    push_line();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    end
    rx_line(1);
    repeat (DIV) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int d0;
    set_digits(7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35);
    d0 = done_cnt;
    send_start();
    repeat (399) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: done=%0d tx=%b busy=%b, required 0 1 0", done_cnt - d0, tx, busy);
    end
    send_start();
    rx_line(2);
    repeat (DIV) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_recover: done=%0d queued=%0d, required 1 0", done_cnt - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stability();
    test_invalid_digit();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ride_uart_tx.md
RIDE_UART_TX -- requirements
Module: ride_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port start  input  1  request to send one report line; sampled each clk.
REQ-006 SHALL have ports distThousands, distHundreds, distTens, distOnes  input  7 each  ASCII distance digits.
REQ-007 SHALL have ports speedTens, speedOnes  input  7 each  ASCII speed digits.
REQ-008 SHALL have port tx  output  1  UART serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a line is being transmitted.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a line completes.

Function
REQ-011 SHALL define DIV = CLK_FREQ_HZ / BAUD (integer truncation); every serial bit lasts exactly DIV clk cycles.
REQ-012 SHALL accept start only when busy=0; start while busy=1 is ignored, with no queuing.
REQ-013 SHALL snapshot all six digit inputs in the accept cycle; input changes during the line do not affect it.
REQ-014 SHALL transmit the 13-byte line "D=" d3 d2 d1 d0 " S=" s1 s0 0x0D 0x0A, in that order.
REQ-015 SHALL replace any snapshot digit outside 0x30..0x39 with 0x3F ('?').
REQ-016 SHALL form each byte as {1'b0, 7-bit code}, sent LSB first.
REQ-017 SHALL frame each byte as start bit 0, 8 data bits, optional parity (REQ-027), then stop bit 1, with no idle gap between bytes.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 FSM transitions SHALL be: IDLE->START on accept; START->DATA after DIV; DATA->DATA for bits 0..6; DATA->PARITY or STOP after bit 7; PARITY->STOP after DIV.
REQ-020 From STOP after DIV, the FSM SHALL go to START if bytes remain, else to IDLE.
REQ-021 SHALL drive tx low and busy high on the clk edge that registers the accept (latency 1 cycle).
REQ-022 SHALL pulse done high for exactly one cycle and drop busy in the same cycle, on the edge ending the last stop bit.
REQ-023 SHALL accept a start asserted in the done cycle and begin a new line with no idle bit.
REQ-024 SHALL keep the byte index (0..12) and bit index (0..7) internal; the byte index wraps to 0 only via IDLE.

Reset
REQ-025 While reset=0 the block SHALL force tx=1, busy=0, done=0, state IDLE, all counters 0 and snapshot registers 0x30, asynchronously.
REQ-026 Reset asserted mid-line SHALL abort the line; no done pulse is produced and transmission restarts only on a new start.

Configuration
REQ-027 With macro RIDE_UART_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) after bit 7, for 11 bits per byte.
REQ-028 Without RIDE_UART_PARITY_EN, the block SHALL omit the PARITY state entirely, for 10 bits per byte.

Verification (CLK_FREQ_HZ=1_000_000, BAUD=100_000, DIV=10)
REQ-029 Idle check: reset 0->1 with no start -> tx=1, busy=0 and done=0 for 500 cycles.
REQ-030 Frame check: digits "0123"/"45", start 1 cycle, no parity -> tx decodes "D=0123 S=45\r\n", busy high 1300 cycles, one done pulse.
REQ-031 Stability and ignore check: digits change to "9999"/"99" at cycle 50 and start pulses at cycle 200 -> line still "D=0123 S=45\r\n", no second line.
REQ-032 Invalid-digit check: distTens=0x41, rest "0"/"0" -> bytes 5..6 read "?0", i.e. 0x3F then 0x30.
REQ-033 Parity check: RIDE_UART_PARITY_EN defined, same as REQ-030 -> 1430 busy cycles; byte 'D' (0x44) parity bit = 0, '1' (0x31) parity bit = 1.
REQ-034 Abort check: reset=0 at cycle 400, released at 410, then start -> tx=1 at 400 with no done, then a full correct line follows.
